fft64_reorder: RTL and testbench

- Output reorder buffer for the 64-point radix-8 FFT datapath; the reader side of the last twiddle/butterfly stage.
- Accepts 64-sample I/Q frames in digit-reversed (radix-8) order and emits them in natural order.
- Ping-pong 2x64 storage sustains one sample per clock with downstream backpressure.

---
 rtl/fft64_reorder.sv | 119 +++++++++++
 tb/tb_fft64_reorder.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft64_reorder.sv
// Output reorder buffer for the 64-point radix-8 FFT.
// Ping-pong banks turn digit-reversed input frames into natural order.
module fft64_reorder #(
    parameter int NBW_IN = 9,
    parameter int NS     = 64
) (
    input  logic                   clk,
    input  logic                   rst_async_n,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic                   i_sof,
    input  logic [1:0][NBW_IN-1:0] i_data,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic                   o_sof,
    output logic [1:0][NBW_IN-1:0] o_data,
    output logic                   o_frm_drop
);

    localparam int AW = $clog2(NS);

    if (NS != 64) begin : g_ns_check
        $error("fft64_reorder: NS must be 64");
    end

    typedef logic [1:0][NBW_IN-1:0] sample_t;

    sample_t       mem [2][NS];

    logic [AW-1:0] wcnt;
    logic [AW-1:0] wcnt_n;
    logic [AW-1:0] rcnt;
    logic [AW-1:0] n_eff;
    logic [AW-1:0] waddr;
    logic          wbank;
    logic          rbank;
    logic [1:0]    bank_full;
    logic [1:0]    full_n;

    logic          acc;
    logic          resync;
    logic          wlast;
    logic          load;
    logic          rlast;

    assign o_ready = !bank_full[wbank];
    assign acc     = i_valid && o_ready;
    assign resync  = acc && i_sof && (wcnt != '0);
    assign wlast   = acc && !resync && (wcnt == AW'(NS - 1));
    assign load    = bank_full[rbank] && (!o_valid || i_ready);
    assign rlast   = load && (rcnt == AW'(NS - 1));

    // A resync sample always lands as position 0 of the new frame
    assign n_eff = resync ? '0 : wcnt;
    assign waddr = {n_eff[2:0], n_eff[5:3]};

    always_comb begin
        wcnt_n = wcnt;
        if (resync) begin
            wcnt_n = AW'(1);
        end else if (wlast) begin
            wcnt_n = '0;
        end else if (acc) begin
            wcnt_n = wcnt + AW'(1);
        end
    end

    // Set and clear never hit the same bank: write side only owns non-full banks
    always_comb begin
        full_n = bank_full;
        if (wlast) begin
            full_n[wbank] = 1'b1;
        end
        if (rlast) begin
            full_n[rbank] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (acc) begin
            mem[wbank][waddr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_async_n) begin
        if (!rst_async_n) begin
            wcnt       <= '0;
            rcnt       <= '0;
            wbank      <= 1'b0;
            rbank      <= 1'b0;
            bank_full  <= '0;
            o_frm_drop <= 1'b0;
        end else begin
            wcnt       <= wcnt_n;
            wbank      <= wbank ^ wlast;
            rbank      <= rbank ^ rlast;
            bank_full  <= full_n;
            o_frm_drop <= resync;
            if (load) begin
                rcnt <= rcnt + AW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_async_n) begin
        if (!rst_async_n) begin
            o_valid <= 1'b0;
            o_sof   <= 1'b0;
            o_data  <= '0;
        end else if (load) begin
            o_valid <= 1'b1;
            o_sof   <= (rcnt == '0);
            o_data  <= mem[rbank][rcnt];
        end else if (i_ready) begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fft64_reorder.sv
// Bench for fft64_reorder: digit-reverse frame model plus directed checks.
module tb_fft64_reorder;

    localparam int NBW = 9;

    logic                 clk         = 1'b0;
    logic                 rst_async_n = 1'b1;
    logic                 i_valid     = 1'b0;
    logic                 i_sof       = 1'b0;
    logic                 i_ready     = 1'b1;
    logic [1:0][NBW-1:0]  i_data      = '0;
    logic                 o_ready;
    logic                 o_valid;
    logic                 o_sof;
    logic                 o_frm_drop;
    logic [1:0][NBW-1:0]  o_data;

    fft64_reorder #(.NBW_IN(NBW), .NS(64)) dut (
        .clk        (clk),
        .rst_async_n(rst_async_n),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_sof      (i_sof),
        .i_data     (i_data),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_sof      (o_sof),
        .o_data     (o_data),
        .o_frm_drop (o_frm_drop)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm, input string why);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: %s", nm, why);
    endtask

    function automatic logic [17:0] mk(input int v);
        logic [17:0] r;
        r[8:0]  = 9'(v);
        r[17:9] = 9'(-v);
        return r;
    endfunction

    // Model and scoreboard state (owned by the monitor)
    logic [17:0] exp_q[$];
    bit          exp_sof_q[$];
    logic [17:0] frm[64];
    int          mcnt = 0;
    bit          drop_exp = 0;
    bit          hold_v = 0;
    logic [17:0] hold_d;
    bit          hold_s;
    int          cyc = 0;
    logic [17:0] cap[$];
    bit          cap_sof[$];
    int          cap_cyc[$];
    int          drop_seen = 0;

    int          stalls = 0;
    bit          done = 0;

    always @(negedge clk) begin
        logic [17:0] nat[64];
        logic [17:0] e;
        bit          s;
        cyc++;
        if (!rst_async_n) begin
            exp_q.delete();
            exp_sof_q.delete();
            mcnt     = 0;
            drop_exp = 0;
            hold_v   = 0;
        end else begin
            check("frm_drop", o_frm_drop, drop_exp);
            if (o_frm_drop) drop_seen++;
            drop_exp = 0;
            if (hold_v) begin
                check("hold_valid", o_valid, 1);
                check("hold_data", o_data, hold_d);
                check("hold_sof", o_sof, hold_s);
            end
            hold_v = o_valid && !i_ready;
            hold_d = o_data;
            hold_s = o_sof;
            if (i_valid && o_ready) begin
                if (i_sof && mcnt != 0) begin
                    drop_exp = 1;
                    mcnt     = 0;
                end
                frm[mcnt] = i_data;
                mcnt++;
                if (mcnt == 64) begin
                    for (int n = 0; n < 64; n++)
                        nat[8 * (n % 8) + n / 8] = frm[n];
                    for (int k = 0; k < 64; k++) begin
                        exp_q.push_back(nat[k]);
                        exp_sof_q.push_back(k == 0);
                    end
                    mcnt = 0;
                end
            end
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    fail("out_unexpected", "output with empty scoreboard");
                end else begin
                    e = exp_q.pop_front();
                    s = exp_sof_q.pop_front();
                    check("out_data", o_data, e);
                    check("out_sof", o_sof, s);
                end
                cap.push_back(o_data);
                cap_sof.push_back(o_sof);
                cap_cyc.push_back(cyc);
            end
        end
    end

    task automatic send(input int iv, input int qv, input bit sof);
        bit rdy;
        int t;
        i_valid   = 1'b1;
        i_sof     = sof;
        i_data[0] = 9'(iv);
        i_data[1] = 9'(qv);
        t = 0;
        forever begin
            rdy = o_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
            stalls++;
            t++;
            if (t > 2000) begin
                fail("send_timeout", "o_ready never rose");
                break;
            end
        end
        i_valid = 1'b0;
        i_sof   = 1'b0;
    endtask

    task automatic drain(input string nm);
        int t;
        t = 0;
        while (!(exp_q.size() == 0 && !o_valid) && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
        end
        check({nm, "_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        fail("watchdog", "simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        int base;
        int s0;
        int d0;
        int sc;
        int v;

        #1 rst_async_n = 1'b0;
        #1;
        check("rst_valid", o_valid, 0);
        check("rst_sof", o_sof, 0);
        check("rst_data", o_data, 0);
        check("rst_drop", o_frm_drop, 0);
        repeat (2) @(posedge clk);
        #2 rst_async_n = 1'b1;
        #1;
        check("rst_ready", o_ready, 1);

        // Single frame, latency and literal reorder points
        base = cap.size();
        s0   = stalls;
        for (int n = 0; n < 64; n++) send(n, -n, n == 0);
        check("t1_valid_at_E", o_valid, 0);
        @(posedge clk);
        #1;
        check("t1_valid_E1", o_valid, 1);
        check("t1_sof_E1", o_sof, 1);
        check("t1_data_E1", o_data, mk(0));
        drain("t1");
        check("t1_count", cap.size() - base, 64);
        check("t1_k0", cap[base + 0], mk(0));
        check("t1_k1", cap[base + 1], mk(8));
        check("t1_k8", cap[base + 8], mk(1));
        check("t1_k9", cap[base + 9], mk(9));
        check("t1_k63", cap[base + 63], mk(63));
        sc = 0;
        for (int k = 0; k < 64; k++) sc += int'(cap_sof[base + k]);
        check("t1_sof_count", sc, 1);
        check("t1_sof_k0", cap_sof[base], 1);
        check("t1_stalls", stalls - s0, 0);

        // Four back-to-back frames
        base = cap.size();
        s0   = stalls;
        for (int f = 0; f < 4; f++)
            for (int n = 0; n < 64; n++) begin
                v = f * 64 + n;
                send(v, -v, n == 0);
            end
        drain("t2");
        check("t2_count", cap.size() - base, 256);
        check("t2_contig", cap_cyc[base + 255] - cap_cyc[base], 255);
        check("t2_stalls", stalls - s0, 0);
        check("t2_f1_k1", cap[base + 65], mk(72));
        check("t2_f3_k8", cap[base + 200], mk(193));
        sc = 0;
        for (int k = 0; k < 256; k++) sc += int'(cap_sof[base + k]);
        check("t2_sof_count", sc, 4);

        // Backpressure: fill both banks
        i_ready = 1'b0;
        base = cap.size();
        s0   = stalls;
        for (int f = 0; f < 2; f++)
            for (int n = 0; n < 64; n++) begin
                v = f * 100 + n + 1;
                send(v, -v, n == 0);
            end
        check("t3_stalls", stalls - s0, 0);
        check("t3_ready_low", o_ready, 0);
        check("t3_valid", o_valid, 1);
        check("t3_data_k0", o_data, mk(1));
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        check("t3_hold_data", o_data, mk(1));
        check("t3_hold_ready", o_ready, 0);
        i_ready = 1'b1;
        repeat (62) begin
            @(posedge clk);
            #1;
        end
        check("t3_ready_before_k63", o_ready, 0);
        @(posedge clk);
        #1;
        check("t3_ready_after_k63", o_ready, 1);
        drain("t3");
        check("t3_count", cap.size() - base, 128);
        check("t3_f1_k0", cap[base + 64], mk(101));
        check("t3_f1_k63", cap[base + 127], mk(164));

        // SOF resync after a partial frame
        d0   = drop_seen;
        base = cap.size();
        for (int n = 0; n < 20; n++) send(50 + n, -(50 + n), n == 0);
        for (int n = 0; n < 64; n++) send(-(n + 1), n + 1, n == 0);
        drain("t4");
        check("t4_drops", drop_seen - d0, 1);
        check("t4_count", cap.size() - base, 64);
        check("t4_k0", cap[base + 0], mk(-1));
        check("t4_k1", cap[base + 1], mk(-9));

        // Random valid/ready over 50 frames
        d0   = drop_seen;
        base = cap.size();
        done = 0;
        fork
            begin
                for (int f = 0; f < 50; f++)
                    for (int n = 0; n < 64; n++) begin
                        if ($urandom_range(0, 2) == 0) begin
                            i_valid = 1'b0;
                            @(posedge clk);
                            #1;
                        end
                        send($urandom_range(0, 511), $urandom_range(0, 511), n == 0);
                    end
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    i_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        i_ready = 1'b1;
        drain("t5");
        check("t5_count", cap.size() - base, 3200);
        check("t5_drops", drop_seen - d0, 0);

        // Reset in the middle of output
        for (int n = 0; n < 64; n++) send(n + 3, -(n + 3), n == 0);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        check("t6_valid_pre", o_valid, 1);
        #1 rst_async_n = 1'b0;
        #1;
        check("t6_rst_valid", o_valid, 0);
        check("t6_rst_sof", o_sof, 0);
        check("t6_rst_data", o_data, 0);
        check("t6_rst_drop", o_frm_drop, 0);
        @(posedge clk);
        #2 rst_async_n = 1'b1;
        #1;
        check("t6_ready", o_ready, 1);
        check("t6_valid_post", o_valid, 0);
        base = cap.size();
        for (int n = 0; n < 64; n++) send(2 * n, -2 * n, n == 0);
        drain("t6");
        check("t6_count", cap.size() - base, 64);
        check("t6_k1", cap[base + 1], mk(16));
        check("t6_k8", cap[base + 8], mk(2));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
